// File: rtl/accel_spi_sequencer.sv
// ADXL345-class SPI register sequencer: writes three config words after reset, then
// reads NUM_AXES two-byte axis registers per frame and publishes them atomically.
module accel_spi_sequencer #(
    parameter int          NUM_AXES      = 3,
    parameter int          DATA_W        = 10,
    parameter logic [7:0]  AXIS_BASE     = 8'h32,
    parameter logic [15:0] CFG0          = 16'h2D08,
    parameter logic [15:0] CFG1          = 16'h2C08,
    parameter logic [15:0] CFG2          = 16'h3100,
    parameter int          GAP_CYCLES    = 4096,
    parameter int          SAMPLE_PERIOD = 2097152
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode_cont,
    input  logic [7:0]                 rxdata,
    input  logic                       done,
    output logic                       transmit,
    output logic [15:0]                txdata,
    output logic [NUM_AXES*DATA_W-1:0] axis_data,
    output logic                       sample_valid,
    output logic                       cfg_done,
    output logic                       busy,
    output logic                       overrun
);

    localparam int AXW   = NUM_AXES * DATA_W;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [PER_W-1:0] PER_MAX  = '1;
    localparam logic [2:0]       CFG_LAST = 3'd2;
    localparam logic [2:0]       RD_LAST  = 3'(2 * NUM_AXES - 1);

    typedef enum logic [2:0] {
        CFG_SEND, CFG_WAIT, GAP, IDLE, RD_SEND, RD_WAIT, PUBLISH, HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             cfg_done_q, cfg_done_d;
    logic             in_rd_q, in_rd_d;
    logic             mode_q, mode_d;
    logic             transmit_q, transmit_d;
    logic [15:0]      txdata_q, txdata_d;
    logic             sample_valid_q, sample_valid_d;
    logic             overrun_q, overrun_d;
    logic [AXW-1:0]   axis_q, shadow_q;
    logic             start_meta_q, start_sync_q, start_prev_q;
    logic             start_rise, late;

    function automatic logic [15:0] cfg_word(input logic [2:0] i);
        case (i)
            3'd0:    return CFG0;
            3'd1:    return CFG1;
            default: return CFG2;
        endcase
    endfunction

    // Read command: bit 7 = read, bit 6 = 0 (single byte), 6-bit register address.
    function automatic logic [15:0] rd_cmd(input logic [2:0] k);
        logic [5:0] addr;
        addr = AXIS_BASE[5:0] + {3'd0, k};
        return {2'b10, addr, 8'h00};
    endfunction

    assign start_rise = start_sync_q & ~start_prev_q;
    assign late       = (per_q >= PER_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CFG_SEND;
            idx_q          <= '0;
            gap_q          <= '0;
            per_q          <= '0;
            cfg_done_q     <= 1'b0;
            in_rd_q        <= 1'b0;
            mode_q         <= 1'b0;
            transmit_q     <= 1'b0;
            txdata_q       <= 16'h0000;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            axis_q         <= '0;
            start_meta_q   <= 1'b0;
            start_sync_q   <= 1'b0;
            start_prev_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            gap_q          <= gap_d;
            per_q          <= per_d;
            cfg_done_q     <= cfg_done_d;
            in_rd_q        <= in_rd_d;
            mode_q         <= mode_d;
            transmit_q     <= transmit_d;
            txdata_q       <= txdata_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
            start_meta_q   <= start;
            start_sync_q   <= start_meta_q;
            start_prev_q   <= start_sync_q;
            if (state_q == PUBLISH) axis_q <= shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RD_WAIT && done) begin
            for (int a = 0; a < NUM_AXES; a++) begin
                if (idx_q[2:1] == 2'(a)) begin
                    if (!idx_q[0]) shadow_q[a*DATA_W +: 8] <= rxdata;
                    else           shadow_q[a*DATA_W+8 +: DATA_W-8] <= rxdata[DATA_W-9:0];
                end
            end
        end
    end

    // SEND states advance once transmit_q is up; right after reset the first
    // CFG_SEND cycle only arms transmit, so the request always lasts one cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        per_d      = (per_q == PER_MAX) ? per_q : per_q + 1'b1;
        cfg_done_d = cfg_done_q;
        in_rd_d    = in_rd_q;
        mode_d     = mode_q;
        case (state_q)
            CFG_SEND: if (transmit_q) state_d = CFG_WAIT;
            CFG_WAIT: if (done) begin
                state_d = GAP;
                gap_d   = '0;
                if (idx_q == CFG_LAST) cfg_done_d = 1'b1;
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (!in_rd_q) begin
                        if (cfg_done_q) state_d = IDLE;
                        else begin
                            state_d = CFG_SEND;
                            idx_d   = idx_q + 1'b1;
                        end
                    end else if (idx_q == RD_LAST) begin
                        state_d = PUBLISH;
                    end else begin
                        state_d = RD_SEND;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            IDLE: begin
                mode_d = mode_cont;
                if (mode_cont ? start_sync_q : start_rise) begin
                    state_d = RD_SEND;
                    idx_d   = '0;
                    in_rd_d = 1'b1;
                    per_d   = '0;
                end
            end
            RD_SEND: if (transmit_q) state_d = RD_WAIT;
            RD_WAIT: if (done) begin
                state_d = GAP;
                gap_d   = '0;
            end
            PUBLISH: begin
                if (!mode_q) begin
                    state_d = IDLE;
                    in_rd_d = 1'b0;
                end else if (late && start_sync_q) begin
                    state_d = RD_SEND;
                    idx_d   = '0;
                    per_d   = '0;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!start_sync_q) begin
                    state_d = IDLE;
                    in_rd_d = 1'b0;
                end else if (late) begin
                    state_d = RD_SEND;
                    idx_d   = '0;
                    per_d   = '0;
                end
            end
            default: state_d = CFG_SEND;
        endcase
    end

    always_comb begin
        transmit_d = (state_d == CFG_SEND) || (state_d == RD_SEND);
        txdata_d   = txdata_q;
        if (state_d == CFG_SEND)     txdata_d = cfg_word(idx_d);
        else if (state_d == RD_SEND) txdata_d = rd_cmd(idx_d);
        sample_valid_d = (state_q == PUBLISH);
        overrun_d      = (state_q == PUBLISH) && mode_q && late;
        busy           = (state_q != IDLE);
    end

    assign transmit     = transmit_q;
    assign txdata       = txdata_q;
    assign axis_data    = axis_q;
    assign sample_valid = sample_valid_q;
    assign cfg_done     = cfg_done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Directed bench for accel_spi_sequencer: two instances (long and short sample period)
// each driven by a byte-level SPI engine model with a fixed done latency.
module tb_accel_spi_sequencer;

    localparam int GAP = 16;
    localparam int LAT = 20;
    localparam int PA  = 5000;
    localparam int PB  = 100;
    localparam int FRAME_CYC = 6 * (1 + LAT + GAP) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic        rst_a = 1'b1, start_a = 1'b0, mode_a = 1'b0, done_a = 1'b0;
    logic [7:0]  rxdata_a = 8'h00;
    logic        transmit_a, sv_a, cfgd_a, busy_a, ov_a;
    logic [15:0] txdata_a;
    logic [29:0] axis_a;

    logic        rst_b = 1'b1, start_b = 1'b0, mode_b = 1'b0, done_b = 1'b0;
    logic [7:0]  rxdata_b = 8'h00;
    logic        transmit_b, sv_b, cfgd_b, busy_b, ov_b;
    logic [15:0] txdata_b;
    logic [29:0] axis_b;

    accel_spi_sequencer #(.GAP_CYCLES(GAP), .SAMPLE_PERIOD(PA)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .mode_cont(mode_a),
        .rxdata(rxdata_a), .done(done_a), .transmit(transmit_a), .txdata(txdata_a),
        .axis_data(axis_a), .sample_valid(sv_a), .cfg_done(cfgd_a), .busy(busy_a),
        .overrun(ov_a)
    );

    accel_spi_sequencer #(.GAP_CYCLES(GAP), .SAMPLE_PERIOD(PB)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .mode_cont(mode_b),
        .rxdata(rxdata_b), .done(done_b), .transmit(transmit_b), .txdata(txdata_b),
        .axis_data(axis_b), .sample_valid(sv_b), .cfg_done(cfgd_b), .busy(busy_b),
        .overrun(ov_b)
    );

    // SPI engine model A: done LAT cycles after transmit, read data from a register file.
    logic [7:0]  regs_a [6];
    logic [15:0] txlog_a [128];
    int          txcyc_a [128];
    int          donecyc_a [128];
    int          pend_a = 0, ntx_a = 0, ndone_a = 0, rdk_a = -1;
    bit          stray_a = 1'b0;

    always @(negedge clk) begin
        done_a = 1'b0;
        if (rst_a) begin
            pend_a = 0;
        end else begin
            if (pend_a > 0) begin
                pend_a--;
                if (pend_a == 0) begin
                    done_a   = 1'b1;
                    rxdata_a = (rdk_a >= 0 && rdk_a < 6) ? regs_a[rdk_a] : 8'h00;
                    if (ndone_a < 128) donecyc_a[ndone_a] = cyc;
                    ndone_a++;
                end
            end
            if (transmit_a === 1'b1) begin
                pend_a = LAT;
                rdk_a  = txdata_a[15] ? int'(txdata_a[13:8]) - 'h32 : -1;
                if (ntx_a < 128) begin
                    txlog_a[ntx_a] = txdata_a;
                    txcyc_a[ntx_a] = cyc;
                end
                ntx_a++;
            end
        end
        if (stray_a) done_a = 1'b1;
    end

    logic [7:0]  regs_b [6];
    logic [15:0] txlog_b [256];
    int          txcyc_b [256];
    int          pend_b = 0, ntx_b = 0, rdk_b = -1;

    always @(negedge clk) begin
        done_b = 1'b0;
        if (rst_b) begin
            pend_b = 0;
        end else begin
            if (pend_b > 0) begin
                pend_b--;
                if (pend_b == 0) begin
                    done_b   = 1'b1;
                    rxdata_b = (rdk_b >= 0 && rdk_b < 6) ? regs_b[rdk_b] : 8'h00;
                end
            end
            if (transmit_b === 1'b1) begin
                pend_b = LAT;
                rdk_b  = txdata_b[15] ? int'(txdata_b[13:8]) - 'h32 : -1;
                if (ntx_b < 256) begin
                    txlog_b[ntx_b] = txdata_b;
                    txcyc_b[ntx_b] = cyc;
                end
                ntx_b++;
            end
        end
    end

    int nsv_a = 0, nov_a = 0, nsv_b = 0, nov_b = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sv_a === 1'b1) nsv_a <= nsv_a + 1;
        if (ov_a === 1'b1) nov_a <= nov_a + 1;
        if (sv_b === 1'b1) nsv_b <= nsv_b + 1;
        if (ov_b === 1'b1) nov_b <= nov_b + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_a = 1'b1;
        tick(4);
        n_checks++; if (transmit_a !== 1'b0) begin n_fail++; $display("FAIL reset_transmit: got %b want 0", transmit_a); end
        n_checks++; if (txdata_a !== 16'h0000) begin n_fail++; $display("FAIL reset_txdata: got %h want 0000", txdata_a); end
        n_checks++; if (axis_a !== 30'h0) begin n_fail++; $display("FAIL reset_axis: got %h want 0", axis_a); end
        n_checks++; if (sv_a !== 1'b0 || ov_a !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got sv=%b ov=%b want 0 0", sv_a, ov_a); end
        n_checks++; if (cfgd_a !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_done: got %b want 0", cfgd_a); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy_a); end
        rst_a = 1'b0;
    endtask

    task automatic test_config;
        logic [15:0] cfgw [3];
        cfgw[0] = 16'h2D08; cfgw[1] = 16'h2C08; cfgw[2] = 16'h3100;
        for (int i = 0; i < 400 && !(cfgd_a === 1'b1 && busy_a === 1'b0); i++) tick(1);
        n_checks++; if (cfgd_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL cfg_finish: got cfg_done=%b busy=%b want 1 0", cfgd_a, busy_a); end
        n_checks++; if (ntx_a != 3) begin n_fail++; $display("FAIL cfg_count: got %0d transactions want 3", ntx_a); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (txlog_a[i] !== cfgw[i]) begin n_fail++; $display("FAIL cfg_word%0d: got %h want %h", i, txlog_a[i], cfgw[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (txcyc_a[i+1] - donecyc_a[i] - 1 != GAP) begin n_fail++; $display("FAIL cfg_gap%0d: got %0d idle cycles want %0d", i, txcyc_a[i+1] - donecyc_a[i] - 1, GAP); end
        end
    endtask

    task automatic test_idle_stray;
        int nt, ns;
        nt = ntx_a; ns = nsv_a;
        stray_a = 1'b1;
        tick(1);
        stray_a = 1'b0;
        tick(30);
        n_checks++; if (busy_a !== 1'b0 || ntx_a != nt || nsv_a != ns) begin n_fail++; $display("FAIL idle_stray_done: got busy=%b tx=%0d sv=%0d want 0 %0d %0d", busy_a, ntx_a, nsv_a, nt, ns); end
    endtask

    task automatic test_single_frame;
        int nt, ns;
        logic [15:0] exp;
        regs_a[0] = 8'h34; regs_a[1] = 8'h02; regs_a[2] = 8'h78;
        regs_a[3] = 8'h01; regs_a[4] = 8'hFF; regs_a[5] = 8'h03;
        nt = ntx_a; ns = nsv_a;
        start_a = 1'b1;
        tick(4);
        start_a = 1'b0;
        for (int i = 0; i < 1000 && nsv_a == ns; i++) tick(1);
        n_checks++; if (axis_a !== {10'h3FF, 10'h178, 10'h234}) begin n_fail++; $display("FAIL single_axis: got %h want %h", axis_a, {10'h3FF, 10'h178, 10'h234}); end
        for (int k = 0; k < 6; k++) begin
            exp = 16'hB200 + 16'(k) * 16'h0100;
            n_checks++; if (txlog_a[nt+k] !== exp) begin n_fail++; $display("FAIL single_cmd%0d: got %h want %h", k, txlog_a[nt+k], exp); end
        end
        tick(50);
        n_checks++; if (nsv_a != ns + 1 || ntx_a != nt + 6) begin n_fail++; $display("FAIL single_once: got sv=%0d tx=%0d want %0d %0d", nsv_a - ns, ntx_a - nt, 1, 6); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b want 0", busy_a); end
    endtask

    task automatic test_start_held;
        int nt, ns;
        regs_a[0] = 8'h00; regs_a[1] = 8'h00; regs_a[2] = 8'hFF;
        regs_a[3] = 8'hFF; regs_a[4] = 8'hAB; regs_a[5] = 8'h01;
        nt = ntx_a; ns = nsv_a;
        start_a = 1'b1;
        tick(10 * FRAME_CYC);
        n_checks++; if (ntx_a != nt + 6 || nsv_a != ns + 1) begin n_fail++; $display("FAIL held_one_frame: got tx=%0d sv=%0d want 6 1", ntx_a - nt, nsv_a - ns); end
        n_checks++; if (axis_a !== {10'h1AB, 10'h3FF, 10'h000}) begin n_fail++; $display("FAIL held_axis: got %h want %h", axis_a, {10'h1AB, 10'h3FF, 10'h000}); end
        start_a = 1'b0;
        tick(20);
        n_checks++; if (ntx_a != nt + 6) begin n_fail++; $display("FAIL held_fall_quiet: got tx=%0d want 6", ntx_a - nt); end
        start_a = 1'b1;
        for (int i = 0; i < 1000 && nsv_a < ns + 2; i++) tick(1);
        start_a = 1'b0;
        n_checks++; if (ntx_a != nt + 12 || nsv_a != ns + 2) begin n_fail++; $display("FAIL held_retoggle: got tx=%0d sv=%0d want 12 2", ntx_a - nt, nsv_a - ns); end
        tick(10);
    endtask

    task automatic test_continuous;
        int nt, ns;
        nt = ntx_a; ns = nsv_a;
        mode_a  = 1'b1;
        start_a = 1'b1;
        for (int i = 0; i < 16000 && ntx_a < nt + 13; i++) tick(1);
        n_checks++; if (ntx_a < nt + 13) begin n_fail++; $display("FAIL cont_timeout: got tx=%0d want >=13", ntx_a - nt); end
        n_checks++; if (txcyc_a[nt+6] - txcyc_a[nt] != PA) begin n_fail++; $display("FAIL cont_period1: got %0d want %0d", txcyc_a[nt+6] - txcyc_a[nt], PA); end
        n_checks++; if (txcyc_a[nt+12] - txcyc_a[nt+6] != PA) begin n_fail++; $display("FAIL cont_period2: got %0d want %0d", txcyc_a[nt+12] - txcyc_a[nt+6], PA); end
        start_a = 1'b0;
        for (int i = 0; i < 1000 && nsv_a < ns + 3; i++) tick(1);
        n_checks++; if (nsv_a != ns + 3 || ntx_a != nt + 18) begin n_fail++; $display("FAIL cont_drop_complete: got sv=%0d tx=%0d want 3 18", nsv_a - ns, ntx_a - nt); end
        tick(1);
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL cont_drop_idle: got busy=%b want 0", busy_a); end
        tick(PA + 200);
        n_checks++; if (ntx_a != nt + 18 || nov_a != 0) begin n_fail++; $display("FAIL cont_quiet: got tx=%0d overruns=%0d want 18 0", ntx_a - nt, nov_a); end
        n_checks++; if (axis_a !== {10'h1AB, 10'h3FF, 10'h000}) begin n_fail++; $display("FAIL cont_axis: got %h want %h", axis_a, {10'h1AB, 10'h3FF, 10'h000}); end
        mode_a = 1'b0;
    endtask

    task automatic test_reset_mid;
        int nt, ns;
        logic [15:0] cfgw [3];
        cfgw[0] = 16'h2D08; cfgw[1] = 16'h2C08; cfgw[2] = 16'h3100;
        nt = ntx_a;
        start_a = 1'b1;
        for (int i = 0; i < 1000 && ntx_a < nt + 4; i++) tick(1);
        start_a = 1'b0;
        tick(5);
        rst_a = 1'b1;
        tick(1);
        n_checks++; if (transmit_a !== 1'b0 || txdata_a !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_tx: got transmit=%b txdata=%h want 0 0000", transmit_a, txdata_a); end
        n_checks++; if (axis_a !== 30'h0 || cfgd_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got axis=%h cfg_done=%b want 0 0", axis_a, cfgd_a); end
        rst_a   = 1'b0;
        stray_a = 1'b1;
        tick(1);
        stray_a = 1'b0;
        ns = nsv_a;
        for (int i = 0; i < 400 && !(cfgd_a === 1'b1 && busy_a === 1'b0); i++) tick(1);
        n_checks++; if (ntx_a != nt + 7 || cfgd_a !== 1'b1) begin n_fail++; $display("FAIL mid_reconfig: got tx=%0d cfg_done=%b want 7 1", ntx_a - nt, cfgd_a); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (txlog_a[nt+4+i] !== cfgw[i]) begin n_fail++; $display("FAIL mid_cfg_word%0d: got %h want %h", i, txlog_a[nt+4+i], cfgw[i]); end
        end
        n_checks++; if (nsv_a != ns || axis_a !== 30'h0) begin n_fail++; $display("FAIL mid_no_publish: got sv=%0d axis=%h want 0 0", nsv_a - ns, axis_a); end
    endtask

    task automatic test_overrun;
        int nt;
        regs_b[0] = 8'h11; regs_b[1] = 8'h01; regs_b[2] = 8'h22;
        regs_b[3] = 8'h02; regs_b[4] = 8'h33; regs_b[5] = 8'h03;
        rst_b = 1'b0;
        for (int i = 0; i < 400 && !(cfgd_b === 1'b1 && busy_b === 1'b0); i++) tick(1);
        n_checks++; if (cfgd_b !== 1'b1 || ntx_b != 3) begin n_fail++; $display("FAIL ovr_config: got cfg_done=%b tx=%0d want 1 3", cfgd_b, ntx_b); end
        nt = ntx_b;
        mode_b  = 1'b1;
        start_b = 1'b1;
        for (int i = 0; i < 2000 && nsv_b < 3; i++) tick(1);
        n_checks++; if (nsv_b != 3 || nov_b != 3) begin n_fail++; $display("FAIL ovr_pulses: got sv=%0d overruns=%0d want 3 3", nsv_b, nov_b); end
        n_checks++; if (axis_b !== {10'h333, 10'h222, 10'h111}) begin n_fail++; $display("FAIL ovr_axis: got %h want %h", axis_b, {10'h333, 10'h222, 10'h111}); end
        n_checks++; if (txcyc_b[nt+6] - txcyc_b[nt] != FRAME_CYC) begin n_fail++; $display("FAIL ovr_b2b1: got %0d want %0d", txcyc_b[nt+6] - txcyc_b[nt], FRAME_CYC); end
        n_checks++; if (txcyc_b[nt+12] - txcyc_b[nt+6] != FRAME_CYC) begin n_fail++; $display("FAIL ovr_b2b2: got %0d want %0d", txcyc_b[nt+12] - txcyc_b[nt+6], FRAME_CYC); end
        n_checks++; if (txlog_b[nt+11] !== 16'hB700) begin n_fail++; $display("FAIL ovr_cmd: got %h want B700", txlog_b[nt+11]); end
        start_b = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            regs_a[i] = 8'h00;
            regs_b[i] = 8'h00;
        end
        test_reset;
        test_config;
        test_idle_stray;
        test_single_frame;
        test_start_held;
        test_continuous;
        test_reset_mid;
        test_overrun;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
